// File: rtl/im_prefetch_buffer.sv
// im_prefetch_buffer: sequential IM fetch into a PC-tagged FWFT FIFO with flush and halt.
// Optional statistics counters are enabled by defining PF_STATS_EN.
module im_prefetch_buffer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic                  im_rd,
    input  logic [DATA_WIDTH-1:0] im_r_data,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  if_ready,
`ifdef PF_STATS_EN
    output logic [15:0]           stat_flushed,
    output logic [15:0]           stat_stall,
`endif
    output logic [PTR_WIDTH:0]    count
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc, issue_pc, pend_pc;
    logic                  pend, issue, flushing, push, pop, credit;
    logic [PTR_WIDTH+1:0]  load;
    logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_p [DEPTH];

    // Occupancy plus both outstanding reads must stay below DEPTH so a push never hits a full FIFO.
    assign load     = {1'b0, count} + {{(PTR_WIDTH+1){1'b0}}, pend} + {{(PTR_WIDTH+1){1'b0}}, im_rd};
    assign credit   = load < (PTR_WIDTH+2)'(DEPTH);
    assign flushing = flush && state != IDLE;
    assign push     = pend && !flushing;
    assign pop      = if_valid && if_ready && !flushing;
    assign if_valid = count != '0;
    assign if_instr = mem_d[rd_ptr];
    assign if_pc    = mem_p[rd_ptr];
    assign issue    = state_nxt == RUN && !flushing && credit;

    // Next state and the PC to issue from; start in IDLE restarts at PC 0.
    always_comb begin
        state_nxt = state;
        issue_pc  = fetch_pc;
        if (state == IDLE) begin
            if (start) begin
                state_nxt = RUN;
                issue_pc  = '0;
            end
        end else begin
            state_nxt = halt ? HALTED : RUN;
        end
    end

    // Fetch state, registered IM request and response tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= '0;
            im_addr  <= '0;
            im_rd    <= 1'b0;
            pend     <= 1'b0;
            pend_pc  <= '0;
        end else begin
            state   <= state_nxt;
            im_rd   <= issue;
            pend    <= im_rd && !flushing;
            pend_pc <= im_addr;
            if (issue) begin
                im_addr  <= issue_pc;
                fetch_pc <= issue_pc + 1'b1;
            end else if (flushing) begin
                fetch_pc <= flush_pc;
            end
        end
    end

    // FIFO pointers and occupancy; flush empties the queue and drops any pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flushing) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // FIFO storage: instruction word tagged with the PC it was fetched from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] <= '0;
                mem_p[i] <= '0;
            end
        end else if (push) begin
            mem_d[wr_ptr] <= im_r_data;
            mem_p[wr_ptr] <= pend_pc;
        end
    end

`ifdef PF_STATS_EN
    logic [16:0] fl_sum;
    assign fl_sum = {1'b0, stat_flushed} + 17'(count) + 17'(pend) + 17'(im_rd);

    // Saturating counters of discarded fetches and of empty-FIFO cycles while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_flushed <= '0;
            stat_stall   <= '0;
        end else if (state == IDLE && start) begin
            stat_flushed <= '0;
            stat_stall   <= '0;
        end else begin
            if (flushing) stat_flushed <= fl_sum[16] ? 16'hFFFF : fl_sum[15:0];
            if (state == RUN && !if_valid && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule

// File: doc/im_prefetch_buffer.md
Name: im_prefetch_buffer

Overview:
- Instruction-fetch front end placed between the instruction memory and the 16-bit pipelined processor's IF stage.
- Issues sequential IM reads from a local fetch PC and stores returned words, tagged with their PC, in a small FIFO.
- Hands entries to the IF stage with a valid/ready handshake.
- Supports branch redirect (flush) and fetch halt, decoupling IM latency from pipeline stalls.

Parameters:
- ADDR_WIDTH, 8, IM address / PC width
- DATA_WIDTH, 16, instruction width
- DEPTH, 4, FIFO entries (power of two, >= 2)
- PTR_WIDTH, 2, log2(DEPTH)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse: begin fetching at PC 0
- halt  input  1  level: stop issuing new IM reads
- flush  input  1  pulse: redirect fetch
- flush_pc  input  ADDR_WIDTH  new fetch PC when flush=1
- im_addr  output  ADDR_WIDTH  IM read address
- im_rd  output  1  IM read enable
- im_r_data  input  DATA_WIDTH  IM read data, valid exactly one cycle after im_rd
- if_valid  output  1  head entry available
- if_instr  output  DATA_WIDTH  head instruction
- if_pc  output  ADDR_WIDTH  head PC
- if_ready  input  1  IF stage accepts head this cycle
- count  output  PTR_WIDTH+1  FIFO occupancy

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; fetch_pc=0; FIFO empty; in-flight flag=0.
  - im_rd=0, im_addr=0, if_valid=0, if_instr=0, if_pc=0, count=0.
- State IDLE:
  - No reads issued.
  - start=1 -> RUN, fetch_pc=0.
  - start is ignored in RUN and HALTED.
- State RUN:
  - im_rd=1 when count + inflight < DEPTH; im_addr=fetch_pc. Outputs registered.
  - Each issue: fetch_pc+1, wrapping 8'hFF -> 8'h00.
  - One read per cycle maximum.
  - halt=1 -> HALTED; no new issue that cycle.
- State HALTED:
  - No issue; FIFO still drains normally.
  - halt=0 -> RUN, resuming at the current fetch_pc.
- Response capture:
  - A read issued in cycle N is captured from im_r_data at the rising edge ending cycle N+1.
  - It is pushed with its issue PC, unless it has been invalidated.
- FIFO:
  - First-word-fall-through: if_valid = (count != 0); if_instr and if_pc always show the head.
  - Pop when if_valid && if_ready.
  - Push and pop in the same cycle is legal; count unchanged.
  - The credit rule guarantees no push when full. Pop when empty is ignored.
- Flush (highest priority, any state except IDLE):
  - FIFO cleared; in-flight response discarded (not pushed).
  - fetch_pc=flush_pc; im_rd=0 that cycle.
  - A pop in the same cycle is dropped, with no data consumed.
  - State after flush: RUN if halt=0, else HALTED.
  - Issue from flush_pc occurs on the next cycle.
- Flush in IDLE: ignored.
- Simultaneous start+flush in IDLE: start wins, PC=0.
- Reset mid-operation: all state cleared immediately; any in-flight response is dropped.
- Startup latency: start sampled at edge E0 -> im_rd=1, im_addr=0 after E0 -> data captured at E2 -> if_valid=1 after E2.
- Steady-state throughput: 1 instruction/cycle with if_ready held high.

Optional Feature:
- Macro: PF_STATS_EN.
- When defined:
  - Adds output stat_flushed (16 bits): saturating count of FIFO entries plus in-flight responses discarded by flush.
  - Adds output stat_stall (16 bits): saturating count of cycles with if_valid=0 in RUN.
  - Both counters reset to 0 on rst_n=0 and on a start accepted in IDLE.
- When undefined: neither port exists; no counter logic.

Test Plan:
- Reset, then start pulse with IM[0..7]=16'h1000..16'h1007 and if_ready=1 -> if_valid rises 2 cycles after start; if_pc sequence 0,1,2,...; if_instr=16'h1000,16'h1001,... one per cycle.
- Hold if_ready=0 after start -> count reaches 4 and stays; im_rd stays 0 once full; raise if_ready -> 4 entries pop (PC 0..3), fetch resumes at PC 4 with no gap or duplicate.
- Flush with flush_pc=8'h20 while count=3 and a read in flight -> next cycle count=0, if_valid=0; im_addr=8'h20 on the following cycle; first popped if_pc=8'h20; old PC never seen. With PF_STATS_EN, stat_flushed=4.
- Halt asserted mid-run with 2 entries queued -> im_rd stays 0; both entries drain with correct PCs; deassert halt -> fetch continues at the next sequential PC.
- Flush with flush_pc=8'hFE -> fetch order 8'hFE, 8'hFF, 8'h00, 8'h01 (wrap verified).
- Assert rst_n=0 for half a cycle mid-run with count=2 -> all outputs 0 immediately; after release, stays IDLE (im_rd=0) until next start.
